// File: rtl/data_mem_pkg.sv
// data_mem_pkg
//   Shared definitions for the data memory unit: access-size encoding,
//   the controller state enum, and small helpers for alignment checking
//   and big-endian lane placement.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Misaligned half/word or the reserved size encoding.
   function automatic logic size_err(input logic [1:0] sz, input logic [1:0] off);
      logic e;
      case (sz)
         SZ_BYTE: e = 1'b0;
         SZ_HALF: e = off[0];
         SZ_WORD: e = (off != 2'b00);
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   // Bit shift between a right-justified datum and its position in the word.
   // Offset 0 is the most significant byte, so a byte at offset o sits at
   // 8*(3-o) and a half at offset o sits at 8*(2-o).
   function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
      logic [4:0] s;
      case (sz)
         SZ_BYTE: s = {~off, 3'b000};
         SZ_HALF: s = {~off[1], 4'b0000};
         default: s = 5'd0;
      endcase
      return s;
   endfunction

   // Byte lanes touched by a legal access; lane 3 holds word bits [31:24].
   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] m;
      case (sz)
         SZ_BYTE: m = 4'b1000 >> off;
         SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram
//   One byte lane of the data memory: single port, 8 bits wide,
//   synchronous write, registered read (read-before-write on the port).
// Ports:
//   clk   - rising-edge clock
//   we    - write enable for this lane
//   addr  - word index
//   wdata - byte to write
//   rdata - byte at addr as of the previous clock edge
module dmem_lane_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Byte-addressable big-endian data memory with byte/half/word loads and
//   stores, alignment checking, sign/zero extension and a 1-cycle response.
//   After reset the storage can optionally be swept to zero, one word per
//   cycle, during which requests are refused.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake (accepted when both high)
//   req_write           - 1 store, 0 load
//   req_size            - 00 byte, 01 half, 10 word, 11 illegal
//   req_signed          - sign-extend loads
//   req_addr            - byte address
//   req_wdata           - right-justified store data
//   rsp_valid           - response for the request accepted last cycle
//   rsp_rdata           - extended load data (0 for stores and errors)
//   rsp_err             - misaligned or illegal-size request
module data_mem_unit
   import data_mem_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int WA_W = ADDR_W - 2;
   localparam logic [WA_W-1:0] LAST_IDX = '1;
   localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   state_t          state;
   logic [WA_W-1:0] clr_cnt;

   logic            accept;
   logic            err;
   logic [1:0]      off;
   logic [4:0]      shift;
   logic [31:0]     wword;

   logic [3:0]            lane_we;
   logic [WA_W-1:0]       lane_addr;
   logic [3:0][7:0]       lane_wd;
   logic [3:0][7:0]       lane_rd;

   // Response pipeline state
   logic       rsp_valid_q;
   logic       rsp_err_q;
   logic       rsp_wr_q;
   logic       rsp_sgn_q;
   logic [1:0] rsp_size_q;
   logic [4:0] rsp_shift_q;

   // Ready is also gated by rst so it drops the instant reset asserts,
   // even when the reset state is IDLE.
   assign req_ready = (state == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign off       = req_addr[1:0];
   assign err       = size_err(req_size, off);
   assign shift     = lane_shift(req_size, off);

   always_comb begin
      wword = '0;
      case (req_size)
         SZ_BYTE: wword = {24'd0, req_wdata[7:0]} << shift;
         SZ_HALF: wword = {16'd0, req_wdata[15:0]} << shift;
         default: wword = req_wdata;
      endcase
   end

   // The single port is shared: the sweep owns it in CLEAR, requests in IDLE.
   always_comb begin
      if (state == ST_CLEAR) begin
         lane_we   = 4'b1111;
         lane_addr = clr_cnt;
         lane_wd   = '0;
      end else begin
         lane_we   = (accept && req_write && !err) ? lane_mask(req_size, off) : 4'b0000;
         lane_addr = req_addr[ADDR_W-1:2];
         lane_wd   = wword;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      dmem_lane_ram #(.AW(WA_W)) u_lane (
         .clk   (clk),
         .we    (lane_we[g]),
         .addr  (lane_addr),
         .wdata (lane_wd[g]),
         .rdata (lane_rd[g])
      );
   end

   // FSM and clear sweep; a reset mid-sweep restarts it from index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RST_STATE;
         clr_cnt <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_IDX) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_sgn_q   <= 1'b0;
         rsp_size_q  <= SZ_BYTE;
         rsp_shift_q <= '0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_err_q   <= err;
            rsp_wr_q    <= req_write;
            rsp_sgn_q   <= req_signed;
            rsp_size_q  <= req_size;
            rsp_shift_q <= shift;
         end
      end
   end

   // Load data returns from the lanes in the response cycle. A store in the
   // previous cycle has already landed, so a following load sees it.
   logic [31:0] rd_shifted;
   logic [31:0] rd_ext;

   always_comb begin
      rd_shifted = lane_rd >> rsp_shift_q;
      rd_ext     = '0;
      case (rsp_size_q)
         SZ_BYTE: rd_ext = {{24{rsp_sgn_q & rd_shifted[7]}},  rd_shifted[7:0]};
         SZ_HALF: rd_ext = {{16{rsp_sgn_q & rd_shifted[15]}}, rd_shifted[15:0]};
         default: rd_ext = rd_shifted;
      endcase
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q && rsp_err_q;
   assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_wr_q) ? rd_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [1:0] sz, input logic sgn,
                      input logic [9:0] a, input logic [31:0] wd,
                      input logic e, input logic [31:0] rd);
      vec_t v;
      v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = a; v.wdata = wd; v.err = e; v.rdata = rd;
      tbl.push_back(v);
   endtask

   // Counts cycles with req_ready low, starting at the current sample point;
   // also counts any rsp_valid seen meanwhile.
   task automatic count_clear(output int cyc, output int rsp_seen);
      cyc = 0;
      rsp_seen = 0;
      while (!req_ready && cyc < 1000) begin
         if (rsp_valid) rsp_seen++;
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int cyc, seen;

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      req_valid = 1'b1;   // must be ignored while in reset
      @(posedge clk); #1;
      chk("rst_ready",     {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_rsp_rdata", rsp_rdata,          32'd0);
      req_valid = 1'b0;

      // Start a sweep, interrupt it at index 100, expect a full fresh sweep.
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("midclear_ready_low", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midclear_rst_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_clear(cyc, seen);
      chk("clear_cycles", cyc, 32'd256);
      chk("clear_no_rsp", seen, 32'd0);

      // Vector table, applied back-to-back one per cycle.
      add(0, 2'b10, 0, 10'h3FC, 0,            0, 32'h00000000);
      add(1, 2'b10, 0, 10'h010, 32'h11223344, 0, 32'h00000000);
      add(0, 2'b00, 0, 10'h010, 0,            0, 32'h00000011);
      add(0, 2'b00, 0, 10'h011, 0,            0, 32'h00000022);
      add(0, 2'b00, 0, 10'h012, 0,            0, 32'h00000033);
      add(0, 2'b00, 0, 10'h013, 0,            0, 32'h00000044);
      add(0, 2'b01, 0, 10'h012, 0,            0, 32'h00003344);
      add(0, 2'b10, 0, 10'h010, 0,            0, 32'h11223344);
      add(1, 2'b00, 0, 10'h021, 32'h00000080, 0, 32'h00000000);
      add(0, 2'b00, 1, 10'h021, 0,            0, 32'hFFFFFF80);
      add(0, 2'b00, 0, 10'h021, 0,            0, 32'h00000080);
      add(0, 2'b01, 1, 10'h020, 0,            0, 32'h00000080);
      add(1, 2'b00, 0, 10'h020, 32'h0000009A, 0, 32'h00000000);
      add(0, 2'b01, 1, 10'h020, 0,            0, 32'hFFFF9A80);
      add(0, 2'b10, 1, 10'h020, 0,            0, 32'h9A800000);
      add(0, 2'b10, 0, 10'h030, 0,            0, 32'h00000000);
      add(1, 2'b10, 0, 10'h031, 32'hDEADBEEF, 1, 32'h00000000);
      add(0, 2'b10, 0, 10'h030, 0,            0, 32'h00000000);
      add(1, 2'b01, 0, 10'h042, 32'h0000ABCD, 0, 32'h00000000);
      add(0, 2'b01, 0, 10'h042, 0,            0, 32'h0000ABCD);
      add(0, 2'b01, 1, 10'h042, 0,            0, 32'hFFFFABCD);
      add(0, 2'b10, 0, 10'h040, 0,            0, 32'h0000ABCD);
      add(0, 2'b01, 0, 10'h043, 0,            1, 32'h00000000);
      add(0, 2'b11, 0, 10'h044, 0,            1, 32'h00000000);
      add(1, 2'b11, 0, 10'h040, 32'h12345678, 1, 32'h00000000);
      add(1, 2'b01, 0, 10'h041, 32'h00005555, 1, 32'h00000000);
      add(0, 2'b10, 0, 10'h040, 0,            0, 32'h0000ABCD);
      add(0, 2'b10, 0, 10'h042, 0,            1, 32'h00000000);
      add(1, 2'b00, 0, 10'h050, 32'hFFFFFF55, 0, 32'h00000000);
      add(1, 2'b00, 0, 10'h053, 32'h12345677, 0, 32'h00000000);
      add(0, 2'b10, 0, 10'h050, 0,            0, 32'h55000077);

      for (int i = 0; i < tbl.size(); i++) begin
         chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
         req_valid  = 1'b1;
         req_write  = tbl[i].wr;
         req_size   = tbl[i].sz;
         req_signed = tbl[i].sgn;
         req_addr   = tbl[i].addr;
         req_wdata  = tbl[i].wdata;
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("v%0d_err", i),   {31'd0, rsp_err},   {31'd0, tbl[i].err});
         chk($sformatf("v%0d_rdata", i), rsp_rdata,          tbl[i].rdata);
      end

      // No request -> no response the following cycle.
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
      chk("idle_err",   {31'd0, rsp_err},   32'd0);
      chk("idle_rdata", rsp_rdata,          32'd0);

      // Reset while a response is in flight: it must never appear.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 10'h010; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("preflight_valid", {31'd0, rsp_valid}, 32'd1);
      chk("preflight_rdata", rsp_rdata, 32'h11223344);
      req_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      req_valid = 1'b0;
      chk("inflight_valid", {31'd0, rsp_valid}, 32'd0);
      chk("inflight_rdata", rsp_rdata,          32'd0);
      chk("inflight_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_clear(cyc, seen);
      chk("reclear_cycles", cyc, 32'd256);
      chk("reclear_no_rsp", seen, 32'd0);

      // The sweep zeroes earlier data.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 10'h010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("after_clear_valid", {31'd0, rsp_valid}, 32'd1);
      chk("after_clear_rdata", rsp_rdata, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
